readout_sequencer: RTL and testbench
====================================

# readout_sequencer

Shot-level controller for the qubit readout datapath. Accepts an arm command for a run of N shots, then for each shot waits for the external trigger, counts the trigger-to-acquisition delay, fires a one-cycle start to the sampler and integrator, and waits for the integrator's IQ result. Each result is presented on a valid/ready output port toward the binning/classifier stage. Sits between the configuration registers and the sampler/integrator pair, and replaces free-running trigger timing with a supervised, per-run sequence.

## Interface

Parameters:
- DELAY_W, 14, width of trigger-to-collect delay (cycles of clk100)
- LEN_W, 11, width of sample_length
- SHOT_W, 16, width of shot count / index
- TIMEOUT, 64, extra cycles beyond sample_length allowed for iq_valid before error

Ports:
- clk100  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle request to start a run
- abort  in  1  terminate run immediately
- num_shots  in  SHOT_W  shots per run; latched on arm
- delay_time  in  DELAY_W  trigger-to-collect delay; latched on arm
- sample_length  in  LEN_W  acquisition length; latched on arm
- trigger  in  1  external shot trigger (already synchronous to clk100)
- iq_valid  in  1  integrator result strobe
- i_val, q_val  in  32 each  integrator result
- start_collect  out  1  one-cycle pulse to sampler and integrator
- sample_length_lat  out  LEN_W  latched sample_length, stable for whole run
- busy  out  1  high in every state except IDLE
- shot_idx  out  SHOT_W  index of current shot, 0-based
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_i, res_q  out  32 each  captured IQ result
- res_last  out  1  qualifies res_valid: final shot of run
- timeout_err  out  1  sticky watchdog error; cleared by next accepted arm
- trig_overrun  out  1  one-cycle pulse: trigger seen while not waiting for one

## Operation

- States: IDLE, WAIT_TRIG, DELAY, WAIT_IQ, OUTPUT.
- IDLE: arm with num_shots != 0 -> latch num_shots, delay_time, sample_length; shot_idx=0; clear timeout_err; go WAIT_TRIG. arm with num_shots == 0 is ignored. arm in any other state is ignored.
- WAIT_TRIG: trigger high -> clear counter, go DELAY.
- DELAY: counter counts clk100 cycles. When counter == delay_lat, pulse start_collect, clear counter, go WAIT_IQ.
- WAIT_IQ: iq_valid high -> capture i_val/q_val into res_i/res_q, set res_valid, set res_last = (shot_idx == num_shots_lat-1), go OUTPUT.
  - Watchdog: counter increments each cycle. When it reaches sample_length_lat + TIMEOUT with no iq_valid -> set timeout_err, go IDLE. No result is produced.
- OUTPUT: hold res_valid, res_i, res_q and res_last stable until res_ready is high. On the handshake cycle, drop res_valid.
  - If res_last -> IDLE.
  - Else shot_idx+1 -> WAIT_TRIG.
- abort: from any state -> IDLE on the next edge. Drops res_valid and any pending start_collect. timeout_err is left unchanged. abort beats arm in the same cycle.
- trig_overrun: pulse when trigger is high and busy is high and state != WAIT_TRIG. That trigger is otherwise ignored. In IDLE, triggers are ignored silently.
- iq_valid outside WAIT_IQ is ignored.
- Width rules:
  - Watchdog compare is done at LEN_W+7 bits, with no overflow.
  - shot_idx never wraps, because the run ends at num_shots_lat-1.
  - num_shots = 2^SHOT_W-1 must be supported.

## Timing

- Reset (reset low) drives every output to 0, including res_i/res_q, and puts the block in IDLE. Deassertion is synchronised internally. The first arm is honoured on the second clk100 edge after release.
- arm sampled at edge A -> busy high from A+1.
- trigger sampled at edge T -> start_collect high for exactly one cycle, at edge T+1+delay_lat. With delay_lat=0 this is T+1.
- iq_valid sampled at edge V -> res_valid high from V+1.
- Handshake at edge H (res_valid & res_ready):
  - next shot -> WAIT_TRIG from H+1, so a trigger is accepted at H+1 at the earliest;
  - last shot -> busy low from H+1.
- res_ready may be high before res_valid. The result is then accepted one cycle after it becomes valid, with no combinational path from res_ready to res_valid.
- abort at edge B -> busy=0 and res_valid=0 from B+1.

## Test plan

- Basic run: num_shots=3, delay=5, trigger; iq_valid 20 cycles after each start, res_ready=1 -> start_collect exactly 6 cycles after each trigger; three results with shot_idx 0,1,2; res_last only on the third; busy falls one cycle after the third handshake.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_i/res_q/res_last stay stable; a trigger during OUTPUT pulses trig_overrun and produces no start_collect.
- Watchdog: sample_length=100, no iq_valid -> timeout_err=1 exactly 164 cycles after start_collect, state IDLE, no res_valid; next arm clears timeout_err.
- Edge config: delay=0 -> start_collect one cycle after trigger. num_shots=0 arm -> busy stays 0. Inputs changed mid-run -> latched values still used.
- Abort/reset: abort during DELAY -> no start_collect, busy=0 next cycle. Assert reset during OUTPUT -> all outputs 0 asynchronously; clean run afterwards.
- Simultaneous events: arm and abort in the same cycle in IDLE -> stays IDLE. iq_valid in the same cycle as the watchdog limit -> result captured, no timeout_err.

Source files
------------

// File: rtl/readout_sequencer.sv
// Shot-level readout controller: arm a run of N shots, then per shot wait for
// trigger, count the collect delay, pulse start_collect and hand off the IQ result.
module readout_sequencer #(
    parameter int DELAY_W = 14,
    parameter int LEN_W   = 11,
    parameter int SHOT_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic [SHOT_W-1:0]  num_shots,
    input  logic [DELAY_W-1:0] delay_time,
    input  logic [LEN_W-1:0]   sample_length,
    input  logic               trigger,
    input  logic               iq_valid,
    input  logic [31:0]        i_val,
    input  logic [31:0]        q_val,
    output logic               start_collect,
    output logic [LEN_W-1:0]   sample_length_lat,
    output logic               busy,
    output logic [SHOT_W-1:0]  shot_idx,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_i,
    output logic [31:0]        res_q,
    output logic               res_last,
    output logic               timeout_err,
    output logic               trig_overrun
);

    localparam int WD_W  = LEN_W + 7;
    localparam int CNT_W = (DELAY_W > WD_W) ? DELAY_W : WD_W;

    typedef enum logic [2:0] {IDLE, WAIT_TRIG, DELAY, WAIT_IQ, OUTPUT} state_t;

    state_t             state;
    logic               rst_sync;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   wd_limit;
    logic [SHOT_W-1:0]  num_shots_lat;
    logic [DELAY_W-1:0] delay_lat;

    // Assertion is asynchronous; release takes effect one edge later.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) rst_sync <= 1'b0;
        else        rst_sync <= 1'b1;
    end

    assign cnt_inc  = cnt + CNT_W'(1);
    assign wd_limit = CNT_W'(sample_length_lat) + CNT_W'(TIMEOUT);

    always_ff @(posedge clk100 or negedge rst_sync) begin
        if (!rst_sync) begin
            state             <= IDLE;
            cnt               <= '0;
            num_shots_lat     <= '0;
            delay_lat         <= '0;
            sample_length_lat <= '0;
            start_collect     <= 1'b0;
            busy              <= 1'b0;
            shot_idx          <= '0;
            res_valid         <= 1'b0;
            res_i             <= '0;
            res_q             <= '0;
            res_last          <= 1'b0;
            timeout_err       <= 1'b0;
            trig_overrun      <= 1'b0;
        end else begin
            start_collect <= 1'b0;
            trig_overrun  <= trigger && (state != IDLE) && (state != WAIT_TRIG);
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm && (num_shots != '0)) begin
                            num_shots_lat     <= num_shots;
                            delay_lat         <= delay_time;
                            sample_length_lat <= sample_length;
                            shot_idx          <= '0;
                            timeout_err       <= 1'b0;
                            busy              <= 1'b1;
                            state             <= WAIT_TRIG;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trigger) begin
                            cnt   <= '0;
                            state <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (cnt == CNT_W'(delay_lat)) begin
                            start_collect <= 1'b1;
                            cnt           <= '0;
                            state         <= WAIT_IQ;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    WAIT_IQ: begin
                        // A result on the limit cycle wins over the watchdog.
                        if (iq_valid) begin
                            res_i     <= i_val;
                            res_q     <= q_val;
                            res_valid <= 1'b1;
                            res_last  <= (shot_idx == num_shots_lat - SHOT_W'(1));
                            state     <= OUTPUT;
                        end else if (cnt_inc == wd_limit) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    OUTPUT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (res_last) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                shot_idx <= shot_idx + SHOT_W'(1);
                                state    <= WAIT_TRIG;
                            end
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: per-cycle vector table for a two-shot
// run plus hand-written sequences for latency, backpressure, watchdog, abort, reset.
module tb_readout_sequencer;

    localparam int DELAY_W = 14;
    localparam int LEN_W   = 11;
    localparam int SHOT_W  = 16;
    localparam int TIMEOUT = 64;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic               clk100 = 1'b0;
    logic               reset = 1'b0;
    logic               arm = 1'b0;
    logic               abort = 1'b0;
    logic [SHOT_W-1:0]  num_shots = '0;
    logic [DELAY_W-1:0] delay_time = '0;
    logic [LEN_W-1:0]   sample_length = '0;
    logic               trigger = 1'b0;
    logic               iq_valid = 1'b0;
    logic [31:0]        i_val = 32'h1234_5678;
    logic [31:0]        q_val = 32'h9abc_def0;
    logic               res_ready = 1'b0;
    logic               start_collect;
    logic [LEN_W-1:0]   sample_length_lat;
    logic               busy;
    logic [SHOT_W-1:0]  shot_idx;
    logic               res_valid;
    logic [31:0]        res_i;
    logic [31:0]        res_q;
    logic               res_last;
    logic               timeout_err;
    logic               trig_overrun;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic              arm, abort, trig, iqv, rdy;
        logic              e_busy, e_start, e_rv, e_last, e_ov;
        logic [SHOT_W-1:0] e_shot;
    } vec_t;

    vec_t vt[15];

    readout_sequencer #(
        .DELAY_W(DELAY_W),
        .LEN_W  (LEN_W),
        .SHOT_W (SHOT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk100           (clk100),
        .reset            (reset),
        .arm              (arm),
        .abort            (abort),
        .num_shots        (num_shots),
        .delay_time       (delay_time),
        .sample_length    (sample_length),
        .trigger          (trigger),
        .iq_valid         (iq_valid),
        .i_val            (i_val),
        .q_val            (q_val),
        .start_collect    (start_collect),
        .sample_length_lat(sample_length_lat),
        .busy             (busy),
        .shot_idx         (shot_idx),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_i            (res_i),
        .res_q            (res_q),
        .res_last         (res_last),
        .timeout_err      (timeout_err),
        .trig_overrun     (trig_overrun)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!start_collect && n < max);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_trig();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    initial begin
        int n;
        int starts;
        logic [5:0] act_v;
        logic [5:0] exp_v;

        // Reset state
        repeat (3) tick();
        check("reset_ctrl", {start_collect, sample_length_lat, busy, shot_idx, res_valid,
                             res_last, timeout_err, trig_overrun}, '0);
        check("reset_iq", {res_i, res_q}, '0);
        reset = 1'b1;
        tick();
        tick();

        // Per-cycle table: two shots, delay 1
        num_shots = 16'd2; delay_time = 14'd1; sample_length = 11'd4;
        vt[0]  = '{H,L,L,L,L, H,L,L,L,L, 16'd0};
        vt[1]  = '{L,L,H,L,L, H,L,L,L,L, 16'd0};
        vt[2]  = '{L,L,L,L,L, H,L,L,L,L, 16'd0};
        vt[3]  = '{L,L,L,L,L, H,H,L,L,L, 16'd0};
        vt[4]  = '{L,L,H,L,L, H,L,L,L,H, 16'd0};
        vt[5]  = '{L,L,L,H,L, H,L,H,L,L, 16'd0};
        vt[6]  = '{L,L,H,L,L, H,L,H,L,H, 16'd0};
        vt[7]  = '{L,L,L,L,H, H,L,L,L,L, 16'd1};
        vt[8]  = '{L,L,H,L,L, H,L,L,L,L, 16'd1};
        vt[9]  = '{L,L,L,L,L, H,L,L,L,L, 16'd1};
        vt[10] = '{L,L,L,L,L, H,H,L,L,L, 16'd1};
        vt[11] = '{L,L,L,H,H, H,L,H,H,L, 16'd1};
        vt[12] = '{L,L,L,L,H, L,L,L,L,L, 16'd0};
        vt[13] = '{L,L,H,L,L, L,L,L,L,L, 16'd0};
        vt[14] = '{H,H,L,L,L, L,L,L,L,L, 16'd0};
        for (int i = 0; i < 15; i++) begin
            arm = vt[i].arm; abort = vt[i].abort; trigger = vt[i].trig;
            iq_valid = vt[i].iqv; res_ready = vt[i].rdy;
            tick();
            act_v = {busy, start_collect, res_valid, vt[i].e_rv ? res_last : 1'b0, trig_overrun, 1'b0};
            exp_v = {vt[i].e_busy, vt[i].e_start, vt[i].e_rv, vt[i].e_last, vt[i].e_ov, 1'b0};
            check($sformatf("vec%0d_ctrl", i), {58'd0, act_v}, {58'd0, exp_v});
            if (vt[i].e_busy)
                check($sformatf("vec%0d_shot", i), {48'd0, shot_idx}, {48'd0, vt[i].e_shot});
        end
        arm = 1'b0; abort = 1'b0; trigger = 1'b0; iq_valid = 1'b0; res_ready = 1'b0;

        // Basic run, with config inputs changed after arm
        num_shots = 16'd3; delay_time = 14'd5; sample_length = 11'd50; res_ready = 1'b1;
        do_arm();
        check("basic_busy", {63'd0, busy}, 64'd1);
        num_shots = 16'd1; delay_time = 14'd0; sample_length = 11'd7;
        for (int s = 0; s < 3; s++) begin
            do_trig();
            wait_start(40, n);
            check("basic_start_lat", n, 64'd6);
            tick();
            check("basic_start_pulse", {63'd0, start_collect}, 64'd0);
            repeat (18) tick();
            i_val = 32'h1000 + s; q_val = 32'h2000 + s; iq_valid = 1'b1;
            tick();
            iq_valid = 1'b0;
            check("basic_result", {res_valid, res_last, shot_idx},
                  {1'b1, (s == 2) ? 1'b1 : 1'b0, 16'(s)});
            check("basic_iq", {res_i, res_q}, {32'h1000 + s, 32'h2000 + s});
            check("basic_latched_len", {53'd0, sample_length_lat}, 64'd50);
            tick();
            check("basic_handshake", {res_valid, busy}, {1'b0, (s != 2) ? 1'b1 : 1'b0});
        end

        // Backpressure with delay 0 and a trigger during OUTPUT
        num_shots = 16'd1; delay_time = 14'd0; sample_length = 11'd10; res_ready = 1'b0;
        do_arm();
        do_trig();
        wait_start(5, n);
        check("delay0_start_lat", n, 64'd1);
        i_val = 32'hcafe_0001; q_val = 32'hbeef_0002; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0; i_val = '0; q_val = '0;
        for (int k = 0; k < 10; k++) begin
            trigger = (k == 3);
            tick();
            trigger = 1'b0;
            check("bp_iq_hold", {res_i, res_q}, {32'hcafe_0001, 32'hbeef_0002});
            check("bp_ctrl_hold", {res_valid, res_last, start_collect}, 3'b110);
            check("bp_overrun", {63'd0, trig_overrun}, {63'd0, (k == 3) ? 1'b1 : 1'b0});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_release", {res_valid, busy}, 2'b00);

        // Watchdog: limit 100 + 64 cycles after start_collect
        num_shots = 16'd1; delay_time = 14'd2; sample_length = 11'd100;
        do_arm();
        do_trig();
        wait_start(10, n);
        check("wd_start_lat", n, 64'd3);
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_err && n < 300);
        check("wd_latency", n, 64'd164);
        check("wd_idle", {busy, res_valid}, 2'b00);
        do_arm();
        check("wd_rearm_clear", {timeout_err, busy}, 2'b01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wd_abort", {63'd0, busy}, 64'd0);

        // iq_valid on the watchdog limit cycle
        do_arm();
        do_trig();
        wait_start(10, n);
        repeat (163) tick();
        check("wd_edge_pre", {timeout_err, busy}, 2'b01);
        iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        check("wd_edge_capture", {res_valid, timeout_err, busy}, 3'b101);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("wd_edge_done", {63'd0, busy}, 64'd0);

        // num_shots == 0 is ignored
        num_shots = 16'd0;
        do_arm();
        check("zero_shots", {63'd0, busy}, 64'd0);

        // Abort during DELAY
        num_shots = 16'd1; delay_time = 14'd10;
        do_arm();
        do_trig();
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        starts = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (start_collect) starts++;
        end
        check("abort_no_start", starts, 64'd0);

        // Asynchronous reset in OUTPUT, then release timing and a clean run
        num_shots = 16'd2; delay_time = 14'd0;
        do_arm();
        do_trig();
        wait_start(5, n);
        iq_valid = 1'b1; i_val = 32'h5555_aaaa;
        tick();
        iq_valid = 1'b0;
        check("rst_pre_valid", {63'd0, res_valid}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_ctrl", {start_collect, sample_length_lat, busy, shot_idx, res_valid,
                                 res_last, timeout_err, trig_overrun}, '0);
        check("rst_async_iq", {res_i, res_q}, '0);
        num_shots = 16'd1; arm = 1'b1;
        #3 reset = 1'b1;
        tick();
        check("rst_release_edge1", {63'd0, busy}, 64'd0);
        tick();
        arm = 1'b0;
        check("rst_release_edge2", {63'd0, busy}, 64'd1);
        do_trig();
        wait_start(5, n);
        check("post_rst_start_lat", n, 64'd1);
        i_val = 32'h0bad_f00d; q_val = 32'h0000_0042; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        check("post_rst_result", {res_i, res_q}, {32'h0bad_f00d, 32'h0000_0042});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("post_rst_done", {res_valid, busy}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
